prim_onehot_sel_gen: RTL

Registered binary-to-onehot select generator: the driving end of a onehot select bus. Accepts a binary address over a valid/ready handshake, drives a registered onehot vector with a matching address and enable, and holds it until release or timeout. Between selections it enforces a break-before-make gap of all-zero cycles. It sits in front of onehot muxes and register-file write-enable fanouts whose consumers check onehot/address/enable consistency.

---
 rtl/prim_onehot_sel_gen_pkg.sv | 15 +
 rtl/prim_onehot_sel_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/prim_onehot_sel_gen_pkg.sv
// rtl/prim_onehot_sel_gen_pkg.sv - state encoding and error-cause indices for prim_onehot_sel_gen
package prim_onehot_sel_gen_pkg;

  // 2'b11 is never assigned; the FSM decodes it as IDLE and recovers on the next edge.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    GAP    = 2'b10
  } state_e;

  localparam int ErrRange   = 0;
  localparam int ErrTimeout = 1;
  localparam int ErrCheck   = 2;

endpackage

// File: rtl/prim_onehot_sel_gen.sv
// rtl/prim_onehot_sel_gen.sv - registered binary-to-onehot select generator with break-before-make gap
// Define PRIM_ONEHOT_SEL_GEN_SELFCHECK_EN to attach prim_onehot_check to the registered outputs.
module prim_onehot_sel_gen
  import prim_onehot_sel_gen_pkg::*;
#(
  parameter int AddrWidth   = 5,
  parameter int OneHotWidth = 2**AddrWidth,
  parameter int GapCycles   = 1,
  parameter int MaxHold     = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  output logic                   req_ready_o,
  input  logic                   release_i,
  output logic [OneHotWidth-1:0] oh_o,
  output logic [AddrWidth-1:0]   addr_o,
  output logic                   en_o,
  output logic                   busy_o,
  output logic [2:0]             err_cause_o,
  output logic                   err_o,
  input  logic                   clr_err_i
);

  localparam int                   GapW    = $clog2(GapCycles + 1);
  localparam logic [GapW-1:0]      GapLast = GapW'(GapCycles - 1);
  localparam logic [AddrWidth:0]   OhLimit = (AddrWidth + 1)'(OneHotWidth);
  localparam logic [OneHotWidth-1:0] OhOne = {{(OneHotWidth - 1){1'b0}}, 1'b1};

  state_e                 state;
  logic [OneHotWidth-1:0] oh;
  logic [AddrWidth-1:0]   addr;
  logic                   en;
  logic                   busy;
  logic [GapW-1:0]        gap_cnt;
  logic [2:0]             err_cause;
  logic [2:0]             err_set;
  logic                   in_active, in_gap, idle, accept, in_range, timeout, check_err;

  assign in_active = (state == ACTIVE);
  assign in_gap    = (state == GAP);
  assign idle      = !(in_active || in_gap);
  assign accept    = idle && req_valid_i;
  assign in_range  = {1'b0, req_addr_i} < OhLimit;

  // The hold counter sits at zero outside ACTIVE, so it starts fresh on every selection.
  if (MaxHold > 0) begin : g_hold
    localparam int               HoldW    = $clog2(MaxHold + 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(MaxHold - 1);
    logic [HoldW-1:0] hold_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        hold_cnt <= '0;
      end else if (!in_active) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HoldLast) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end

    assign timeout = in_active && (hold_cnt == HoldLast);
  end else begin : g_no_hold
    assign timeout = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      oh      <= '0;
      addr    <= '0;
      en      <= 1'b0;
      busy    <= 1'b0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ACTIVE: begin
          if (release_i || timeout) begin
            state   <= GAP;
            oh      <= '0;
            addr    <= '0;
            en      <= 1'b0;
            gap_cnt <= '0;
          end
        end
        GAP: begin
          if (gap_cnt == GapLast) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          if (accept && in_range) begin
            state <= ACTIVE;
            oh    <= OhOne << req_addr_i;
            addr  <= req_addr_i;
            en    <= 1'b1;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef PRIM_ONEHOT_SEL_GEN_SELFCHECK_EN
  prim_onehot_check #(
    .AddrWidth            (AddrWidth),
    .OneHotWidth          (OneHotWidth),
    .AddrCheck            (1),
    .EnableCheck          (1),
    .StrictCheck          (1),
    .EnableAlertTriggerSVA(0)
  ) u_check (
    .clk_i  (clk_i),
    .rst_ni (~rst_i),
    .oh_i   (oh),
    .addr_i (addr),
    .en_i   (en),
    .err_o  (check_err)
  );
`else
  assign check_err = 1'b0;
`endif

  // A release in the timeout cycle wins, so no timeout cause is raised then.
  always_comb begin
    err_set             = '0;
    err_set[ErrRange]   = accept && !in_range;
    err_set[ErrTimeout] = timeout && !release_i;
    err_set[ErrCheck]   = check_err;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cause <= '0;
    end else if (clr_err_i) begin
      err_cause <= err_set;
    end else begin
      err_cause <= err_cause | err_set;
    end
  end

  assign req_ready_o = idle;
  assign oh_o        = oh;
  assign addr_o      = addr;
  assign en_o        = en;
  assign busy_o      = busy;
  assign err_cause_o = err_cause;
  assign err_o       = |err_cause;

endmodule
